// File: rtl/issue_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {instr, pc, pred_taken}
// with registered-state handshakes and no push-to-issue bypass.
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             fetch_valid_i,
    input  logic [XLEN-1:0]  fetch_instr_i,
    input  logic [XLEN-1:0]  fetch_pc_i,
    input  logic             fetch_pred_taken_i,
    output logic             issue_ready_o,
    output logic             issue_valid_o,
    output logic [XLEN-1:0]  issue_instr_o,
    output logic [XLEN-1:0]  issue_pc_o,
    output logic             issue_pred_taken_o,
    input  logic             issue_ready_i,
    output logic [CNT_W-1:0] count_o,
    output logic             almost_full_o
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic   w_push;
    logic   w_pop;
    logic   w_clear;
    entry_t w_head;

    // Handshakes depend only on the registered count, so issue_ready_i never
    // reaches issue_ready_o combinationally.
    assign issue_ready_o = (r_count != CNT_W'(DEPTH));
    assign issue_valid_o = (r_count != '0);
    assign almost_full_o = (r_count >= CNT_W'(DEPTH - 1));
    assign count_o       = r_count;

    assign w_push  = fetch_valid_i && issue_ready_o;
    assign w_pop   = issue_valid_o && issue_ready_i;
    assign w_clear = rst_i || flush_i;

    assign w_head             = r_mem[r_head];
    assign issue_instr_o      = w_head.instr;
    assign issue_pc_o         = w_head.pc;
    assign issue_pred_taken_o = w_head.pred_taken;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately not reset; stale contents are invisible once count is 0.
    always_ff @(posedge clk_i) begin
        if (w_push && !w_clear) begin
            r_mem[r_tail] <= '{instr: fetch_instr_i, pc: fetch_pc_i, pred_taken: fetch_pred_taken_i};
        end
    end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries; power of two, >= 2.
REQ-002 Parameter XLEN, default 32, width of PC and instruction fields.
REQ-003 Parameter CNT_W, default $clog2(DEPTH)+1, width of occupancy count.
REQ-004 Port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_i  input  1  reset, synchronous, active-high.
REQ-006 Port flush_i  input  1  discard all entries (branch redirect).
REQ-007 Port fetch_valid_i  input  1  fetch offers an instruction.
REQ-008 Port fetch_instr_i  input  XLEN  instruction word from fetch.
REQ-009 Port fetch_pc_i  input  XLEN  PC of offered instruction.
REQ-010 Port fetch_pred_taken_i  input  1  branch prediction bit from fetch.
REQ-011 Port issue_ready_o  output  1  queue can accept; fed to fetch as its issue-ready input.
REQ-012 Port issue_valid_o  output  1  head entry valid toward decode/issue.
REQ-013 Port issue_instr_o  output  XLEN  head instruction.
REQ-014 Port issue_pc_o  output  XLEN  head PC.
REQ-015 Port issue_pred_taken_o  output  1  head prediction bit.
REQ-016 Port issue_ready_i  input  1  decode/issue consumes head this cycle.
REQ-017 Port count_o  output  CNT_W  current occupancy, 0..DEPTH.
REQ-018 Port almost_full_o  output  1  occupancy >= DEPTH-1.

Function
REQ-019 Storage SHALL be a circular buffer of DEPTH entries {instr, pc, pred_taken}, head and tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH.
REQ-020 Push SHALL occur when fetch_valid_i && issue_ready_o; entry written at tail, tail incremented.
REQ-021 Pop SHALL occur when issue_valid_o && issue_ready_i; head incremented.
REQ-022 issue_ready_o SHALL equal (count != DEPTH), registered-state only; no combinational path from issue_ready_i.
REQ-023 issue_valid_o SHALL equal (count != 0); no bypass: pushed entry visible at outputs the cycle after push (latency 1).
REQ-024 issue_instr_o, issue_pc_o, issue_pred_taken_o SHALL show head entry contents; value undefined-but-stable when empty, no X required to be driven.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and move both pointers, including when count == DEPTH-1 and when count == 1.
REQ-026 When full, push SHALL not occur even if a pop happens in the same cycle (issue_ready_o low).
REQ-027 When empty, pop SHALL not occur regardless of issue_ready_i.
REQ-028 count_o SHALL be +1 on push only, -1 on pop only, unchanged otherwise; never exceeds DEPTH nor underflows.
REQ-029 flush_i SHALL, in the next cycle, set head = tail = 0, count = 0; any push or pop in the flush cycle is discarded.
REQ-030 Entry order SHALL be strict FIFO; no entry dropped or duplicated outside flush/reset.
REQ-031 Pointer wrap SHALL be seamless: entry at index DEPTH-1 followed by index 0.

Reset
REQ-032 On rst_i high at a rising edge: head = 0, tail = 0, count = 0; rst_i has priority over flush_i, push, pop.
REQ-033 Reset values: issue_valid_o = 0, issue_ready_o = 1, count_o = 0, almost_full_o = 0; storage array not reset.
REQ-034 Reset asserted mid-operation SHALL discard all entries exactly as flush.

Verification
REQ-035 Reset then push A (pc 0x100), B (0x104) on consecutive cycles, issue_ready_i low -> count_o 2, issue_pc_o 0x100; raise issue_ready_i -> pops A then B, issue_valid_o low after.
REQ-036 Push 8 entries with issue_ready_i low -> count_o 8, issue_ready_o 0, almost_full_o 1 from count 7; 9th fetch_valid_i held, not accepted.
REQ-037 Full queue, fetch_valid_i and issue_ready_i high one cycle -> one pop, no push, count_o 7; next cycle push accepted, count_o 8.
REQ-038 Count 3, steady push+pop every cycle for 20 cycles -> count_o stays 3, issued PCs in exact push order across pointer wrap.
REQ-039 Count 5, flush_i high with simultaneous push and pop -> next cycle count_o 0, issue_valid_o 0, issue_ready_o 1; following push appears at head.
REQ-040 Count 4, rst_i and flush_i high together -> next cycle all reset values of REQ-033.
